alu_op_sequencer: RTL and testbench

- Initiator side of the ALU operation interface: accepts one operation per valid/ready handshake, reads operands from an internal 4-entry register file, and drives the ALU operand and select inputs.
- Waits a fixed latency, then captures the ALU result and flags and writes the result back.
- Sits between the instruction decode stage and the combinational ALU, and owns the architectural flags register.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_op_sequencer_regfile.sv | 34 +++
 rtl/alu_op_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU select codes, flag positions and sequencer states
package alu_pkg;

    typedef enum logic [3:0] {
        OP_MOV = 4'd0,
        OP_CMP = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_MUL = 4'd4,
        OP_DIV = 4'd5,
        OP_XOR = 4'd6,
        OP_AND = 4'd7,
        OP_NOT = 4'd8,
        OP_SHL = 4'd9,
        OP_SHR = 4'd10
    } alu_op_e;

    localparam int unsigned ALU_OP_LAST = 10;
    localparam int unsigned FLAG_Z      = 0;
    localparam int unsigned FLAG_C      = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } seq_state_e;

    function automatic logic op_is_legal(input logic [3:0] code);
        return code <= 4'(ALU_OP_LAST);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_regfile.sv
// rtl/alu_op_sequencer_regfile.sv - 4xN register file, two operand reads, one debug read, one write
module seq_regfile #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [1:0]   waddr,
    input  logic [N-1:0] wdata,
    input  logic [1:0]   raddr_a,
    input  logic [1:0]   raddr_b,
    input  logic [1:0]   dbg_idx,
    output logic [N-1:0] rdata_a,
    output logic [N-1:0] rdata_b,
    output logic [N-1:0] dbg_data
);

    logic [N-1:0] regs [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a  = regs[raddr_a];
    assign rdata_b  = regs[raddr_b];
    assign dbg_data = regs[dbg_idx];

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issues one operation at a time to an external ALU and writes the result back
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int N       = 4,
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [3:0]   op_code,
    input  logic [1:0]   op_rd,
    input  logic [1:0]   op_ra,
    input  logic [1:0]   op_rb,
    input  logic         op_imm_en,
    input  logic [N-1:0] op_imm,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_select,
    input  logic [N-1:0] alu_result,
    input  logic [1:0]   alu_flags,
    output logic [1:0]   flags_q,
    output logic         done,
    output logic         err,
    input  logic [1:0]   dbg_idx,
    output logic [N-1:0] dbg_data
);

    localparam logic [1:0] CNT_INIT = 2'(ALU_LAT - 1);

    seq_state_e   state;
    logic [1:0]   rd_q;
    logic         wr_q;
    logic         fail_q;
    logic [1:0]   cnt;
    logic [N-1:0] rdata_a;
    logic [N-1:0] rdata_b;
    logic [N-1:0] b_val;
    logic         reject;
    logic         rf_we;

    assign op_ready = (state == IDLE);
    assign b_val    = op_imm_en ? op_imm : rdata_b;
    // Illegal codes and divide-by-zero bypass the ALU entirely and retire with err.
    assign reject   = !op_is_legal(op_code) || (op_code == OP_DIV && b_val == '0);
    assign rf_we    = (state == WB) && !fail_q && wr_q;

    seq_regfile #(.N(N)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (rd_q),
        .wdata    (alu_result),
        .raddr_a  (op_ra),
        .raddr_b  (op_rb),
        .dbg_idx  (dbg_idx),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_select <= '0;
            rd_q       <= '0;
            wr_q       <= 1'b0;
            fail_q     <= 1'b0;
            cnt        <= '0;
            flags_q    <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        rd_q <= op_rd;
                        wr_q <= (op_code != OP_CMP);
                        if (reject) begin
                            fail_q <= 1'b1;
                            state  <= WB;
                        end else begin
                            // Operands are presented from the accept edge so they are stable through ISSUE..WB.
                            fail_q     <= 1'b0;
                            alu_a      <= rdata_a;
                            alu_b      <= b_val;
                            alu_select <= op_code;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= CNT_INIT;
                    state <= (ALU_LAT <= 1) ? WB : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        state <= WB;
                    end
                end
                WB: begin
                    if (!fail_q) begin
                        flags_q <= alu_flags;
                    end
                    done  <= 1'b1;
                    err   <= fail_q;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - two sequencer instances (latency 1 and 3) against a behavioural ALU and register model
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    logic         op_valid   [2];
    logic         op_ready   [2];
    logic [3:0]   op_code    [2];
    logic [1:0]   op_rd      [2];
    logic [1:0]   op_ra      [2];
    logic [1:0]   op_rb      [2];
    logic         op_imm_en  [2];
    logic [N-1:0] op_imm     [2];
    logic [N-1:0] alu_a      [2];
    logic [N-1:0] alu_b      [2];
    logic [3:0]   alu_select [2];
    logic [N-1:0] alu_result [2];
    logic [1:0]   alu_flags  [2];
    logic [1:0]   flags_q    [2];
    logic         done       [2];
    logic         err        [2];
    logic [1:0]   dbg_idx    [2];
    logic [N-1:0] dbg_data   [2];

    logic [N-1:0] mregs  [2][4];
    logic [1:0]   mflags [2];

    int total = 0;
    int bad   = 0;

    alu_op_sequencer #(.N(N), .ALU_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid[0]), .op_ready(op_ready[0]),
        .op_code(op_code[0]), .op_rd(op_rd[0]), .op_ra(op_ra[0]), .op_rb(op_rb[0]),
        .op_imm_en(op_imm_en[0]), .op_imm(op_imm[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
        .alu_select(alu_select[0]), .alu_result(alu_result[0]), .alu_flags(alu_flags[0]),
        .flags_q(flags_q[0]), .done(done[0]), .err(err[0]), .dbg_idx(dbg_idx[0]),
        .dbg_data(dbg_data[0])
    );

    alu_op_sequencer #(.N(N), .ALU_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid[1]), .op_ready(op_ready[1]),
        .op_code(op_code[1]), .op_rd(op_rd[1]), .op_ra(op_ra[1]), .op_rb(op_rb[1]),
        .op_imm_en(op_imm_en[1]), .op_imm(op_imm[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
        .alu_select(alu_select[1]), .alu_result(alu_result[1]), .alu_flags(alu_flags[1]),
        .flags_q(flags_q[1]), .done(done[1]), .err(err[1]), .dbg_idx(dbg_idx[1]),
        .dbg_data(dbg_data[1])
    );

    // Behavioural ALU: returns {carry, zero, result}.
    function automatic logic [N+1:0] alu_fn(input logic [3:0] s, input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        int ia;
        int ib;
        int f;
        logic c;
        logic [N-1:0] r;
        ia = int'(a);
        ib = int'(b);
        c  = 1'b0;
        case (s)
            4'd0:       f = ib;
            4'd1, 4'd3: begin f = ia - ib; c = (ia < ib); end
            4'd2:       begin f = ia + ib; c = (f >= (1 << N)); end
            4'd4:       begin f = ia * ib; c = (f >= (1 << N)); end
            4'd5:       f = (ib == 0) ? 0 : ia / ib;
            4'd6:       f = ia ^ ib;
            4'd7:       f = ia & ib;
            4'd8:       f = ~ia;
            4'd9:       begin f = ia << ib; c = (f >= (1 << N)); end
            4'd10:      f = ia >> ib;
            default:    f = 0;
        endcase
        r = f[N-1:0];
        return {c, (r == '0), r};
    endfunction

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            {alu_flags[k], alu_result[k]} = alu_fn(alu_select[k], alu_a[k], alu_b[k]);
        end
    end

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input int k, input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_idx[k] = 2'(i);
            #1;
            check(tag, 32'(dbg_data[k]), 32'(mregs[k][i]));
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mflags[k] = '0;
            for (int i = 0; i < 4; i++) mregs[k][i] = '0;
        end
    endtask

    task automatic run_op(input int k, input logic [3:0] code, input logic [1:0] rd,
                          input logic [1:0] ra, input logic [1:0] rb, input logic ie,
                          input logic [N-1:0] imm);
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N+1:0] res;
        logic fail;
        int cyc;
        int exp_lat;
        @(negedge clk);
        check("ready_before", 32'(op_ready[k]), 32'd1);
        op_valid[k] = 1'b1; op_code[k] = code; op_rd[k] = rd; op_ra[k] = ra;
        op_rb[k] = rb; op_imm_en[k] = ie; op_imm[k] = imm;
        a = mregs[k][ra];
        b = ie ? imm : mregs[k][rb];
        fail = (code > 4'd10) || (code == 4'd5 && b == '0);
        exp_lat = fail ? 1 : lat(k) + 1;
        @(posedge clk); #1;
        op_valid[k] = 1'b0;
        op_code[k] = 4'($urandom); op_imm[k] = N'($urandom);
        cyc = 0;
        while (!done[k] && cyc < 12) begin
            check("ready_busy", 32'(op_ready[k]), 32'd0);
            if (!fail) begin
                check("alu_select_held", 32'(alu_select[k]), 32'(code));
                check("alu_a_held", 32'(alu_a[k]), 32'(a));
                check("alu_b_held", 32'(alu_b[k]), 32'(b));
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(exp_lat));
        check("done", 32'(done[k]), 32'd1);
        check("err", 32'(err[k]), 32'(fail));
        check("ready_after", 32'(op_ready[k]), 32'd1);
        if (!fail) begin
            res = alu_fn(code, a, b);
            if (code != 4'd1) mregs[k][rd] = res[N-1:0];
            mflags[k] = res[N+1:N];
        end
        check("flags", 32'(flags_q[k]), 32'(mflags[k]));
        check_regs(k, "regs");
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done[k]), 32'd0);
    endtask

    initial begin
        int acc;
        int last;
        int dn;
        for (int k = 0; k < 2; k++) begin
            op_valid[k] = 1'b0; op_code[k] = '0; op_rd[k] = '0; op_ra[k] = '0;
            op_rb[k] = '0; op_imm_en[k] = 1'b0; op_imm[k] = '0; dbg_idx[k] = '0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_ready", 32'(op_ready[k]), 32'd1);
            check("rst_done", 32'(done[k]), 32'd0);
            check("rst_err", 32'(err[k]), 32'd0);
            check("rst_alu_a", 32'(alu_a[k]), 32'd0);
            check("rst_alu_b", 32'(alu_b[k]), 32'd0);
            check("rst_select", 32'(alu_select[k]), 32'd0);
            check("rst_flags", 32'(flags_q[k]), 32'd0);
            check_regs(k, "rst_regs");
        end

        // Directed sequence on the latency-1 instance.
        run_op(0, 4'd0, 2'd1, 2'd0, 2'd0, 1'b1, 4'd3);
        run_op(0, 4'd2, 2'd2, 2'd1, 2'd0, 1'b1, 4'd4);
        check("add_reg2", 32'(mregs[0][2]), 32'd7);
        run_op(0, 4'd1, 2'd3, 2'd1, 2'd0, 1'b1, 4'd3);
        check("cmp_zflag", 32'(flags_q[0][FLAG_Z]), 32'd1);
        run_op(0, 4'd5, 2'd0, 2'd1, 2'd0, 1'b1, 4'd0);
        run_op(0, 4'd13, 2'd2, 2'd1, 2'd1, 1'b0, 4'd0);

        // Backpressure on the latency-3 instance with op_valid held high.
        run_op(1, 4'd0, 2'd1, 2'd0, 2'd0, 1'b1, 4'd3);
        @(negedge clk);
        op_valid[1] = 1'b1; op_code[1] = 4'd4; op_rd[1] = 2'd3; op_ra[1] = 2'd1;
        op_rb[1] = 2'd0; op_imm_en[1] = 1'b1; op_imm[1] = 4'd5;
        acc = 0; last = -1; dn = 0;
        for (int c = 0; c < 20; c++) begin
            if (op_ready[1]) begin
                acc++;
                if (last >= 0) check("accept_spacing", 32'(c - last), 32'd5);
                last = c;
            end
            @(posedge clk); #1;
            if (done[1]) dn++;
            @(negedge clk);
        end
        op_valid[1] = 1'b0;
        check("accept_count", 32'(acc), 32'd4);
        check("done_count", 32'(dn), 32'd4);
        mregs[1][3] = 4'hF;
        mflags[1] = 2'b00;
        check("mul_flags", 32'(flags_q[1]), 32'(mflags[1]));
        check_regs(1, "mul_regs");

        // Randomized operations on both instances.
        for (int i = 0; i < 24; i++) begin
            run_op(i % 2, 4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom),
                   2'($urandom), 1'($urandom), N'($urandom));
        end

        // Reset while the latency-3 instance is in WAIT.
        @(negedge clk);
        op_valid[1] = 1'b1; op_code[1] = 4'd2; op_rd[1] = 2'd0; op_ra[1] = 2'd1;
        op_imm_en[1] = 1'b1; op_imm[1] = 4'd1;
        @(posedge clk); #1;
        op_valid[1] = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midrst_select", 32'(alu_select[1]), 32'd0);
        check("midrst_alu_a", 32'(alu_a[1]), 32'd0);
        check("midrst_done", 32'(done[1]), 32'd0);
        check("midrst_flags", 32'(flags_q[1]), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (done[1]) dn++;
        end
        check("midrst_no_done", 32'(dn), 32'd0);
        check_regs(0, "midrst_regs0");
        check_regs(1, "midrst_regs1");

        for (int i = 0; i < 6; i++) begin
            run_op(i % 2, 4'($urandom_range(0, 10)), 2'($urandom), 2'($urandom),
                   2'($urandom), 1'($urandom), N'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
